// File: rtl/ledr_pwm_blink_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ledr_pwm_blink_driver: PWM dimming, blinking and inversion between the     |
// | LEDR PIO and the pins. Macro LEDR_GAMMA_EN selects squared duty mapping.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ledr_pwm_blink_driver #(
  parameter int NUM_LEDS     = 18,
  parameter int PRESCALE_DIV = 195,
  parameter int BLINK_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_pattern,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] ledr
);

  localparam int                PSC_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PSC_W-1:0]  PSC_MAX  = PSC_W'(PRESCALE_DIV - 1);
  localparam logic [BLINK_W-1:0] HALF_RST = BLINK_W'(250);

  logic [2:0]         ctrl;
  logic [7:0]         duty;
  logic [BLINK_W-1:0] half;
  logic [PSC_W-1:0]   psc;
  logic [7:0]         pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic               wr, wr_half, tick, frame_end, pwm_on, gate;
  logic [7:0]         eff_duty;
  logic [BLINK_W-1:0] half_m1;
  logic               unused_wdata;

  assign wr        = chipselect && !write_n;
  assign wr_half   = wr && (address == 2'd2);
  assign tick      = (psc == PSC_MAX);
  assign frame_end = tick && (pwm_cnt == 8'hFF);
  assign half_m1   = ((half == '0) ? BLINK_W'(1) : half) - BLINK_W'(1);
  assign unused_wdata = ^writedata;

`ifdef LEDR_GAMMA_EN
  assign eff_duty = (duty == 8'hFF) ? 8'hFF : 8'(({8'd0, duty} * {8'd0, duty}) >> 8);
`else
  assign eff_duty = duty;
`endif

  assign pwm_on = (eff_duty == 8'hFF) || (pwm_cnt < eff_duty);
  assign gate   = (ctrl[0] ? pwm_on : 1'b1) & (ctrl[1] ? ~blink_phase : 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= 3'd0;
      duty <= 8'hFF;
      half <= HALF_RST;
    end else if (wr) begin
      case (address)
        2'd0:    ctrl <= writedata[2:0];
        2'd1:    duty <= writedata[7:0];
        2'd2:    half <= writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc     <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      psc <= tick ? '0 : psc + PSC_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A BLINK_HALF write outranks the terminal count, so it suppresses that toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!ctrl[1]) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wr_half) begin
      blink_cnt <= '0;
    end else if (frame_end) begin
      if (blink_cnt >= half_m1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ledr <= '0;
    else          ledr <= (led_pattern & {NUM_LEDS{gate}}) ^ {NUM_LEDS{ctrl[2]}};
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata[2:0]         = ctrl;
      2'd1: readdata[7:0]         = duty;
      2'd2: readdata[BLINK_W-1:0] = half;
      default: begin
        readdata[NUM_LEDS-1:0] = ledr;
        readdata[31]           = blink_phase;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ledr_pwm_blink_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ledr_pwm_blink_driver: randomized self-checking bench with a frame-    |
// | arithmetic reference model. Revision: 1.0                                  |
// +----------------------------------------------------------------------------+
module tb_ledr_pwm_blink_driver;
  localparam int N     = 18;
  localparam int P     = 2;
  localparam int BW    = 16;
  localparam int FRAME = P * 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  led_pattern = '0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [N-1:0]  ledr;

  always #5 clk = ~clk;

  ledr_pwm_blink_driver #(.NUM_LEDS(N), .PRESCALE_DIV(P), .BLINK_W(BW)) dut (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .ledr(ledr)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counters derived from cycles elapsed since reset release.
  logic [2:0]    m_ctrl;
  logic [7:0]    m_duty;
  logic [BW-1:0] m_half;
  int            m_c, m_frames;
  logic          m_phase;
  logic [N-1:0]  m_ledr;
  int            mism;
  logic [31:0]   f_got, f_exp;

  function automatic int eff(input int d);
`ifdef LEDR_GAMMA_EN
    if (d == 255) return 255;
    return (d * d) / 256;
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return {24'd0, m_duty};
      2'd2:    return {16'd0, m_half};
      default: return {m_phase, 13'd0, m_ledr};
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'd0; m_duty = 8'hFF; m_half = 16'd250;
    m_c = 0; m_frames = 0; m_phase = 1'b0; m_ledr = '0;
  endtask

  task automatic model_step();
    int  pwm, e, hl;
    bit  tick, fend, on, gate, wr;
    pwm  = (m_c / P) % 256;
    tick = (m_c % P) == P - 1;
    fend = tick && (pwm == 255);
    e    = eff(int'(m_duty));
    on   = (e == 255) || (pwm < e);
    gate = (m_ctrl[0] ? on : 1'b1) && (m_ctrl[1] ? !m_phase : 1'b1);
    m_ledr = (gate ? led_pattern : '0) ^ {N{m_ctrl[2]}};
    wr = chipselect && !write_n;
    hl = (m_half == 0) ? 1 : int'(m_half);
    if (!m_ctrl[1]) begin
      m_frames = 0; m_phase = 1'b0;
    end else if (wr && address == 2'd2) begin
      m_frames = 0;
    end else if (fend) begin
      m_frames++;
      if (m_frames >= hl) begin m_phase = !m_phase; m_frames = 0; end
    end
    if (wr) begin
      case (address)
        2'd0: m_ctrl = writedata[2:0];
        2'd1: m_duty = writedata[7:0];
        2'd2: m_half = writedata[BW-1:0];
        default: ;
      endcase
    end
    m_c++;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    if (ledr !== m_ledr || readdata !== exp_rd(address)) begin
      if (mism == 0) begin
        f_got = (ledr !== m_ledr) ? 32'(ledr) : readdata;
        f_exp = (ledr !== m_ledr) ? 32'(m_ledr) : exp_rd(address);
      end
      mism++;
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic test_reset();
    logic [31:0] exp_def [3];
    exp_def[0] = 32'd0; exp_def[1] = 32'hFF; exp_def[2] = 32'd250;
    reset_n = 1'b0; led_pattern = 18'h3FFFF;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ledr !== '0) begin fails++; $display("FAIL reset_ledr got=%h exp=0", ledr); end
    for (int a = 0; a < 3; a++) begin
      address = 2'(a); #1;
      tests++;
      if (readdata !== exp_def[a]) begin
        fails++; $display("FAIL reset_reg%0d got=%h exp=%h", a, readdata, exp_def[a]);
      end
    end
    model_reset(); mism = 0;
    reset_n = 1'b1;
    cyc();
    address = 2'd3; #1;
    tests++;
    if (ledr !== 18'h3FFFF) begin fails++; $display("FAIL release_ledr got=%h exp=3ffff", ledr); end
    tests++;
    if (readdata !== 32'h0003FFFF) begin fails++; $display("FAIL release_status got=%h exp=0003ffff", readdata); end
  endtask

  task automatic test_pwm(input logic [7:0] d);
    int hi, e, exp_hi;
    mism = 0;
    led_pattern = 18'h00001;
    wr_reg(2'd1, {24'd0, d});
    wr_reg(2'd0, 32'd1);
    repeat (2) cyc();
    hi = 0;
    repeat (FRAME) begin cyc(); if (ledr[0]) hi++; end
    e = eff(int'(d));
    exp_hi = (e == 255) ? FRAME : P * e;
    tests++;
    if (hi !== exp_hi) begin fails++; $display("FAIL pwm_high duty=%h got=%0d exp=%0d", d, hi, exp_hi); end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL pwm_model duty=%h errs=%0d got=%h exp=%h", d, mism, f_got, f_exp); end
  endtask

  task automatic test_invert();
    mism = 0;
    led_pattern = 18'h00F0F;
    wr_reg(2'd0, 32'd4);
    cyc();
    tests++;
    if (ledr !== 18'h3F0F0) begin fails++; $display("FAIL invert got=%h exp=3f0f0", ledr); end
    led_pattern = '0;
    cyc();
    tests++;
    if (ledr !== 18'h3FFFF) begin fails++; $display("FAIL invert_zero got=%h exp=3ffff", ledr); end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL invert_model errs=%0d got=%h exp=%h", mism, f_got, f_exp); end
  endtask

  task automatic test_blink();
    int n;
    mism = 0;
    led_pattern = 18'h2AAAA;
    wr_reg(2'd0, 32'd0);
    wr_reg(2'd2, 32'd2);
    wr_reg(2'd0, 32'd2);
    address = 2'd3;
    cyc();
    tests++;
    if (ledr !== 18'h2AAAA || readdata[31] !== 1'b0) begin
      fails++; $display("FAIL blink_start got=%h/%b exp=2aaaa/0", ledr, readdata[31]);
    end
    n = 0;
    while (ledr !== '0 && n < 3 * FRAME) begin cyc(); n++; end
    n = 0;
    do begin n++; cyc(); end while (ledr === '0 && n < 4 * FRAME);
    tests++;
    if (n !== 2 * FRAME) begin fails++; $display("FAIL blink_off_len got=%0d exp=%0d", n, 2 * FRAME); end
    n = 0;
    do begin n++; cyc(); end while (ledr === 18'h2AAAA && n < 4 * FRAME);
    tests++;
    if (n !== 2 * FRAME) begin fails++; $display("FAIL blink_on_len got=%0d exp=%0d", n, 2 * FRAME); end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL blink_model errs=%0d got=%h exp=%h", mism, f_got, f_exp); end
  endtask

  task automatic test_half_write();
    int k;
    logic p0;
    mism = 0;
    led_pattern = 18'h155AA;
    wr_reg(2'd2, 32'd0);
    address = 2'd3; #1;
    p0 = readdata[31]; k = 0;
    while (readdata[31] === p0 && k < 2 * FRAME) begin cyc(); k++; end
    p0 = readdata[31]; k = 0;
    do begin k++; cyc(); end while (readdata[31] === p0 && k < 3 * FRAME);
    tests++;
    if (k !== FRAME) begin fails++; $display("FAIL half0_period got=%0d exp=%0d", k, FRAME); end
    k = 0;
    while ((m_c % FRAME) != FRAME - 1 && k < 2 * FRAME) begin cyc(); k++; end
    p0 = readdata[31];
    wr_reg(2'd2, 32'd5);
    address = 2'd3; #1;
    tests++;
    if (readdata[31] !== p0) begin fails++; $display("FAIL half_wr_terminal phase got=%b exp=%b", readdata[31], p0); end
    k = 0;
    do begin k++; cyc(); end while (readdata[31] === p0 && k < 8 * FRAME);
    tests++;
    if (k !== 5 * FRAME) begin fails++; $display("FAIL half_wr_next got=%0d exp=%0d", k, 5 * FRAME); end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL half_model errs=%0d got=%h exp=%h", mism, f_got, f_exp); end
  endtask

  task automatic test_random();
    logic [1:0] a;
    mism = 0;
    for (int i = 0; i < 40; i++) begin
      led_pattern = N'($urandom);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd2) wr_reg(a, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3));
      else           wr_reg(a, $urandom);
      address = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 300)) cyc();
    end
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL random_model errs=%0d got=%h exp=%h", mism, f_got, f_exp); end
  endtask

  task automatic test_reset_mid();
    mism = 0;
    led_pattern = 18'h3FFFF;
    wr_reg(2'd2, 32'd1);
    wr_reg(2'd0, 32'd2);
    repeat (3) cyc();
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (ledr !== '0) begin fails++; $display("FAIL async_reset_ledr got=%h exp=0", ledr); end
    address = 2'd0; #1;
    tests++;
    if (readdata !== 32'd0) begin fails++; $display("FAIL mid_reset_ctrl got=%h exp=0", readdata); end
    address = 2'd2; #1;
    tests++;
    if (readdata !== 32'd250) begin fails++; $display("FAIL mid_reset_half got=%0d exp=250", readdata); end
    address = 2'd3; #1;
    tests++;
    if (readdata !== 32'd0) begin fails++; $display("FAIL mid_reset_status got=%h exp=0", readdata); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    cyc();
    tests++;
    if (ledr !== 18'h3FFFF) begin fails++; $display("FAIL post_reset_ledr got=%h exp=3ffff", ledr); end
    wr_reg(2'd1, 32'h80);
    wr_reg(2'd0, 32'd3);
    address = 2'd3;
    repeat (3 * FRAME) cyc();
    tests++;
    if (mism !== 0) begin fails++; $display("FAIL post_reset_model errs=%0d got=%h exp=%h", mism, f_got, f_exp); end
  endtask

  initial begin
    test_reset();
    test_pwm(8'h40);
    test_pwm(8'h00);
    test_pwm(8'hFF);
    test_pwm(8'($urandom_range(1, 254)));
    test_invert();
    test_blink();
    test_half_write();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
